// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-neuron blocks.
// Default sizes here match a 4-input neuron with 4-bit weights.
package snn_pkg;

  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } lif_state_e;

  localparam int DEF_NUM_PRE = 4;
  localparam int DEF_W_WIDTH = 4;
  localparam int ADAPT_STEP  = 8;

  // One extra bit beyond the exact bound keeps the sum safely unsigned.
  function automatic int sum_width(input int num_pre, input int w_width);
    return w_width + $clog2(num_pre) + 1;
  endfunction

  localparam int SUM_WIDTH = sum_width(DEF_NUM_PRE, DEF_W_WIDTH);

endpackage

// File: rtl/weighted_spike_adder.sv
// Combinational sum of the packed weights whose pre-synaptic spike is set.
// Input 0 owns the most significant weight slice.
module weighted_spike_adder
  import snn_pkg::*;
#(
  parameter int NUM_PRE = DEF_NUM_PRE,
  parameter int W_WIDTH = DEF_W_WIDTH,
  parameter int SUM_W   = sum_width(NUM_PRE, W_WIDTH)
) (
  input  logic [NUM_PRE-1:0]         pre_spike,
  input  logic [NUM_PRE*W_WIDTH-1:0] weight,
  output logic [SUM_W-1:0]           syn
);

  always_comb begin
    syn = '0;
    for (int i = 0; i < NUM_PRE; i++) begin
      if (pre_spike[i]) begin
        syn = syn + SUM_W'(weight[(NUM_PRE-1-i)*W_WIDTH +: W_WIDTH]);
      end
    end
  end

endmodule

// File: rtl/lif_post_neuron.sv
// Leaky integrate-and-fire post-synaptic neuron with refractory period.
// Define LIF_ADAPT_EN to add a spike-driven adaptive threshold.
module lif_post_neuron
  import snn_pkg::*;
#(
  parameter int NUM_PRE       = DEF_NUM_PRE,
  parameter int W_WIDTH       = DEF_W_WIDTH,
  parameter int V_WIDTH       = 8,
  parameter int THRESHOLD     = 32,
  parameter int LEAK_SHIFT    = 3,
  parameter int REFRAC_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NUM_PRE-1:0]         pre_spike,
  input  logic [NUM_PRE*W_WIDTH-1:0] weight,
  output logic                       post_spike,
  output logic [V_WIDTH-1:0]         membrane,
  output logic                       refractory,
  output logic [7:0]                 spike_count
);

  localparam int SW   = sum_width(NUM_PRE, W_WIDTH);
  localparam int VW2  = V_WIDTH + 2;
  localparam int RC_W = (REFRAC_CYCLES > 1) ? $clog2(REFRAC_CYCLES) : 1;
  localparam logic [VW2-1:0]  V_MAX     = VW2'((2 ** V_WIDTH) - 1);
  localparam logic [RC_W-1:0] RC_RELOAD = RC_W'((REFRAC_CYCLES > 0) ? REFRAC_CYCLES - 1 : 0);

  lif_state_e          state_q, state_d;
  logic [V_WIDTH-1:0]  v_q, v_d;
  logic                post_q, post_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [RC_W-1:0]     rcnt_q, rcnt_d;
  logic [SW-1:0]       syn;
  logic [VW2-1:0]      v_ext, v_next, thr_eff;
  logic                fire;

  weighted_spike_adder #(
    .NUM_PRE (NUM_PRE),
    .W_WIDTH (W_WIDTH),
    .SUM_W   (SW)
  ) u_adder (
    .pre_spike (pre_spike),
    .weight    (weight),
    .syn       (syn)
  );

  assign v_ext  = VW2'(v_q);
  assign v_next = v_ext - (v_ext >> LEAK_SHIFT) + VW2'(syn);

`ifdef LIF_ADAPT_EN
  logic [7:0] adapt_q, adapt_d;
  assign thr_eff = VW2'(THRESHOLD) + VW2'(adapt_q);
`else
  assign thr_eff = VW2'(THRESHOLD);
`endif

  // Compared before clamping so a saturated membrane still fires.
  assign fire = en && (state_q == INTEGRATE) && (v_next >= thr_eff);

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    post_d  = 1'b0;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
`ifdef LIF_ADAPT_EN
    adapt_d = adapt_q;
`endif
    if (en) begin
      case (state_q)
        INTEGRATE: begin
          if (fire) begin
            v_d    = '0;
            post_d = 1'b1;
            cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            if (REFRAC_CYCLES > 0) begin
              state_d = REFRACTORY;
              rcnt_d  = RC_RELOAD;
            end
`ifdef LIF_ADAPT_EN
            adapt_d = ({1'b0, adapt_q} + 9'(ADAPT_STEP) > 9'd255) ? 8'hFF
                                                                 : adapt_q + 8'(ADAPT_STEP);
`endif
          end else begin
            v_d = (v_next > V_MAX) ? V_MAX[V_WIDTH-1:0] : v_next[V_WIDTH-1:0];
`ifdef LIF_ADAPT_EN
            if (adapt_q != 8'd0) adapt_d = adapt_q - 8'd1;
`endif
          end
        end
        REFRACTORY: begin
          v_d = '0;
          if (rcnt_q == '0) state_d = INTEGRATE;
          else              rcnt_d  = rcnt_q - RC_W'(1);
        end
        default: state_d = INTEGRATE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= INTEGRATE;
      v_q     <= '0;
      post_q  <= 1'b0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
`ifdef LIF_ADAPT_EN
      adapt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      post_q  <= post_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
`ifdef LIF_ADAPT_EN
      adapt_q <= adapt_d;
`endif
    end
  end

  assign post_spike  = post_q;
  assign membrane    = v_q;
  assign refractory  = (state_q == REFRACTORY);
  assign spike_count = cnt_q;

endmodule

// File: tb/tb_lif_post_neuron.sv
// Directed self-checking bench for lif_post_neuron (default parameters).
// Expected values are hand-derived; LIF_ADAPT_EN selects the adaptive-threshold expectations.
module tb_lif_post_neuron;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  pre_spike;
  logic [15:0] weight;
  logic        post_spike;
  logic [7:0]  membrane;
  logic        refractory;
  logic [7:0]  spike_count;

  int checks = 0;
  int errors = 0;

  lif_post_neuron dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .pre_spike   (pre_spike),
    .weight      (weight),
    .post_spike  (post_spike),
    .membrane    (membrane),
    .refractory  (refractory),
    .spike_count (spike_count)
  );

  initial forever #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] v, input logic p,
                         input logic r, input logic [7:0] c);
    chk({tag, "_membrane"}, 32'(membrane), 32'(v));
    chk({tag, "_post"}, 32'(post_spike), 32'(p));
    chk({tag, "_refr"}, 32'(refractory), 32'(r));
    chk({tag, "_count"}, 32'(spike_count), 32'(c));
  endtask

  initial begin
    int n;
    // reset with random inputs
    rst_n = 1'b1; en = 1'b1;
    pre_spike = 4'($urandom); weight = 16'($urandom);
    step();
    pre_spike = 4'($urandom); weight = 16'($urandom);
    step();
    chk_all("reset", 8'd0, 1'b0, 1'b0, 8'd0);

    // leak: one 15 pulse then decay 15,14,13,12
    rst_n = 1'b0; weight = 16'hFFFF; pre_spike = 4'b1000;
    step();
    chk_all("leak0", 8'd15, 1'b0, 1'b0, 8'd0);
    pre_spike = 4'b0000;
    step(); chk_all("leak1", 8'd14, 1'b0, 1'b0, 8'd0);
    step(); chk_all("leak2", 8'd13, 1'b0, 1'b0, 8'd0);
    step(); chk_all("leak3", 8'd12, 1'b0, 1'b0, 8'd0);

    // accumulate 10 per cycle: 10,19,27 then fire at v_next=34
    rst_n = 1'b1; step(); rst_n = 1'b0;
    weight = 16'hAAAA; pre_spike = 4'b0001;
    step(); chk_all("acc1", 8'd10, 1'b0, 1'b0, 8'd0);
    step(); chk_all("acc2", 8'd19, 1'b0, 1'b0, 8'd0);
    step(); chk_all("acc3", 8'd27, 1'b0, 1'b0, 8'd0);
    step(); chk_all("acc_fire", 8'd0, 1'b1, 1'b1, 8'd1);
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("acc_refr", 8'd0, 1'b0, 1'b1, 8'd1);
    end
    step(); chk_all("acc_back", 8'd0, 1'b0, 1'b0, 8'd1);
    step(); chk("acc2_v10", 32'(membrane), 32'd10);
    step(); chk("acc2_v19", 32'(membrane), 32'd19);
    step(); chk("acc2_v27", 32'(membrane), 32'd27);
    step();
`ifdef LIF_ADAPT_EN
    // adapt decayed 8->4, threshold 37 not reached by 34
    chk_all("adapt_nofire", 8'd34, 1'b0, 1'b0, 8'd1);
    step();
    chk_all("adapt_fire", 8'd0, 1'b1, 1'b1, 8'd2);
`else
    chk_all("acc2_fire", 8'd0, 1'b1, 1'b1, 8'd2);
    step();
    chk_all("acc2_after", 8'd0, 1'b0, 1'b1, 8'd2);
`endif

    // en=0 holds v=27 with spikes present, then fire, then reset mid-refractory
    rst_n = 1'b1; step(); rst_n = 1'b0;
    step(); step(); step();
    chk("en_pre", 32'(membrane), 32'd27);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); chk_all("en_hold", 8'd27, 1'b0, 1'b0, 8'd0);
    end
    en = 1'b1;
    step(); chk_all("en_fire", 8'd0, 1'b1, 1'b1, 8'd1);
    en = 1'b0;
    step(); chk_all("en_nostretch", 8'd0, 1'b0, 1'b1, 8'd1);
    en = 1'b1;
    rst_n = 1'b1;
    step(); chk_all("rst_refr", 8'd0, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b0;

    // immediate fire, 4 refractory cycles, fire on first INTEGRATE cycle
    weight = 16'hFFFF; pre_spike = 4'b1111;
    step(); chk_all("imm_fire", 8'd0, 1'b1, 1'b1, 8'd1);
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("imm_refr", 8'd0, 1'b0, 1'b1, 8'd1);
    end
    step(); chk_all("imm_exit", 8'd0, 1'b0, 1'b0, 8'd1);
    step(); chk_all("imm_fire2", 8'd0, 1'b1, 1'b1, 8'd2);

    // long stimulus: spike counter saturates at 255
    rst_n = 1'b1; step(); rst_n = 1'b0;
    n = 0;
    while (spike_count != 8'd255 && n < 20000) begin
      step();
      n++;
    end
    chk("sat_reach", 32'(spike_count), 32'd255);
    for (int i = 0; i < 20; i++) step();
    chk("sat_hold", 32'(spike_count), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
